// File: rtl/pipe_skid_register.sv
// Posedge pipeline register with a one-entry skid buffer, registered in_ready and synchronous flush.
// Optional saturating stall counter is compiled in when PIPE_SKID_STATS_EN is defined.
module pipe_skid_register #(
    parameter int WIDTH = 32
`ifdef PIPE_SKID_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       state
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);

    // Handshake: a word moves on a posedge only when valid and ready are both high
    // in the preceding cycle; a producer holding valid keeps its data stable until taken.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = state_q[0];
    assign out_data  = main_q;
    assign state     = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash wins over any transfer; data registers keep their stale contents.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

`ifdef PIPE_SKID_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: directed vectors, a queue-based reference model checked every
// negedge, and literal expectations; PIPE_SKID_STATS_EN adds the saturating stall counter checks.
module tb_pipe_skid_register;

    localparam int W = 32;
`ifdef PIPE_SKID_STATS_EN
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [1:0]   state;
`ifdef PIPE_SKID_STATS_EN
    logic [CW-1:0] stall_count;
`endif

    int total = 0;
    int bad = 0;

    pipe_skid_register #(
        .WIDTH(W)
`ifdef PIPE_SKID_STATS_EN
        , .CNT_WIDTH(CW)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .state(state)
`ifdef PIPE_SKID_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity two.
    logic [W-1:0] exp_q[$];
`ifdef PIPE_SKID_STATS_EN
    int mcnt = 0;
`endif

    always @(posedge clock or negedge reset) begin
        bit pop;
        bit push;
        if (!reset) begin
            exp_q.delete();
`ifdef PIPE_SKID_STATS_EN
            mcnt = 0;
`endif
        end else begin
`ifdef PIPE_SKID_STATS_EN
            if (exp_q.size() > 0 && !out_ready && mcnt < MAXC) mcnt++;
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                pop  = (exp_q.size() > 0) && out_ready;
                push = in_valid && (exp_q.size() < 2);
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(in_data);
            end
        end
    end

    always @(negedge clock) begin
        chk("m_in_ready", W'(in_ready), W'(exp_q.size() < 2));
        chk("m_out_valid", W'(out_valid), W'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("m_out_data", out_data, exp_q[0]);
`ifdef PIPE_SKID_STATS_EN
        chk("m_stall_count", W'(stall_count), W'(mcnt));
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", W'(in_ready), 1);
        reset = 1'b1;
        tick();

        // Streaming 1,2,3 with out_ready high
        drive(1, 32'h1, 1, 0); tick();
        chk("str1_valid", W'(out_valid), 1);
        chk("str1_data", out_data, 32'h1);
        chk("str1_ready", W'(in_ready), 1);
        drive(1, 32'h2, 1, 0); tick();
        chk("str2_data", out_data, 32'h2);
        chk("str2_ready", W'(in_ready), 1);
        drive(1, 32'h3, 1, 0); tick();
        chk("str3_data", out_data, 32'h3);
        drive(0, 32'h0, 1, 0); tick();
        chk("str_drain", W'(out_valid), 0);

        // Backpressure: A then B fill the stage, C is refused
        drive(1, 32'hA, 0, 0); tick();
        chk("bp_a_data", out_data, 32'hA);
        chk("bp_a_ready", W'(in_ready), 1);
        drive(1, 32'hB, 0, 0); tick();
        chk("bp_full_ready", W'(in_ready), 0);
        chk("bp_full_data", out_data, 32'hA);
        chk("bp_full_state", W'(state), 32'h3);
        drive(1, 32'hC, 0, 0); tick();
        chk("bp_c_refused", W'(in_ready), 0);
        chk("bp_hold_data", out_data, 32'hA);
        drive(1, 32'hC, 1, 0); tick();
        chk("bp_out_b", out_data, 32'hB);
        chk("bp_ready_back", W'(in_ready), 1);
        tick();
        chk("bp_out_c", out_data, 32'hC);
        drive(0, 32'h0, 1, 0); tick();
        chk("bp_empty", W'(out_valid), 0);

        // Flush while FULL with a word offered
        drive(1, 32'hA, 0, 0); tick();
        drive(1, 32'hB, 0, 0); tick();
        drive(1, 32'hD, 0, 1); tick();
        chk("fl_valid", W'(out_valid), 0);
        chk("fl_ready", W'(in_ready), 1);
        drive(0, 32'h0, 1, 0); tick();
        chk("fl_no_d", W'(out_valid), 0);

        // Asynchronous reset while FULL
        drive(1, 32'h11, 0, 0); tick();
        drive(1, 32'h22, 0, 0); tick();
        chk("ar_full", W'(in_ready), 0);
        drive(0, 32'h0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", W'(out_valid), 0);
        chk("ar_ready", W'(in_ready), 1);
        chk("ar_data", out_data, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_after", W'(out_valid), 0);

`ifdef PIPE_SKID_STATS_EN
        // Stall counter saturation, untouched by flush
        drive(1, 32'h5, 0, 0); tick();
        drive(0, 32'h0, 0, 0);
        repeat (5) tick();
        chk("st_sat", W'(stall_count), 3);
        drive(0, 32'h0, 0, 1); tick();
        drive(0, 32'h0, 1, 0); tick();
        chk("st_flush", W'(stall_count), 3);
`endif

        // Mixed traffic checked by the model
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 32'hFFFF)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            tick();
        end
        drive(0, 32'h0, 1, 0);
        repeat (3) tick();
        chk("end_empty", W'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
